// File: rtl/lvt_pkg.sv
// rtl/lvt_pkg.sv - shared types and helpers for the live-value-table multiport RAM
package lvt_pkg;

    typedef enum logic {ST_INIT, ST_READY} lvt_init_state_e;

    // Width of one LVT entry; a single write port still needs one bit.
    function automatic int lvt_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lvt_table.sv
// rtl/lvt_table.sv - live value table: records which write port last wrote each address
module lvt_table
    import lvt_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 0,
    parameter int AW       = $clog2(DEPTH),
    parameter int SW       = lvt_sel_w(WR_PORTS)
) (
    input  logic          clk,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic          wr_req   [WR_PORTS],
    input  logic [AW-1:0] wr_addr  [WR_PORTS],
    output logic          wr_win   [WR_PORTS],
    input  logic [AW-1:0] rd_addr  [RD_PORTS],
    output logic [SW-1:0] rd_sel   [RD_PORTS],
    output logic          rd_fwd   [RD_PORTS]
);

    logic [SW-1:0] sel_mem [DEPTH];

    // A port loses its write if any higher-index port targets the same address.
    always_comb begin
        for (int w = 0; w < WR_PORTS; w++) begin
            wr_win[w] = wr_req[w];
            for (int j = w + 1; j < WR_PORTS; j++) begin
                if (wr_req[j] && (wr_addr[j] == wr_addr[w])) begin
                    wr_win[w] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            sel_mem[clr_addr] <= '0;
        end else begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_win[w]) begin
                    sel_mem[wr_addr[w]] <= SW'(w);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rd_sel[r] = sel_mem[rd_addr[r]];
            rd_fwd[r] = 1'b0;
            if (BYPASS != 0) begin
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (wr_win[w] && (wr_addr[w] == rd_addr[r])) begin
                        rd_sel[r] = SW'(w);
                        rd_fwd[r] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lvt_multiport_ram.sv
// rtl/lvt_multiport_ram.sv - multi-write/multi-read RAM built from an LVT and replicated banks
module lvt_multiport_ram
    import lvt_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 0,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en    [WR_PORTS],
    input  logic [AW-1:0]    wr_addr  [WR_PORTS],
    input  logic [WIDTH-1:0] wr_data  [WR_PORTS],
    input  logic             rd_en    [RD_PORTS],
    input  logic [AW-1:0]    rd_addr  [RD_PORTS],
    output logic [WIDTH-1:0] rd_data  [RD_PORTS],
    output logic             rd_valid [RD_PORTS],
    output logic             init_done,
    output logic             wr_conflict
);

    localparam int SW = lvt_sel_w(WR_PORTS);

    lvt_init_state_e state_q, state_d;
    logic [AW-1:0]   clr_cnt;
    logic            ready;
    logic            clr_last;
    logic            conflict_d;

    logic             wr_req  [WR_PORTS];
    logic             wr_win  [WR_PORTS];
    logic [SW-1:0]    rd_sel  [RD_PORTS];
    logic             rd_fwd  [RD_PORTS];
    logic [WIDTH-1:0] rd_word [RD_PORTS];

    // One copy per (write port, read port) pair so each bank has a single writer and reader.
    logic [WIDTH-1:0] bank [WR_PORTS][RD_PORTS][DEPTH];

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign clr_last  = (int'(clr_cnt) == DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && !clr_last) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && clr_last) begin
            state_d = ST_READY;
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int w = 0; w < WR_PORTS; w++) begin
            wr_req[w] = wr_en[w] && ready && (int'(wr_addr[w]) < DEPTH);
            for (int j = w + 1; j < WR_PORTS; j++) begin
                if (wr_en[w] && wr_en[j] && (wr_addr[w] == wr_addr[j])) begin
                    conflict_d = ready;
                end
            end
        end
    end

    lvt_table #(
        .DEPTH    (DEPTH),
        .WR_PORTS (WR_PORTS),
        .RD_PORTS (RD_PORTS),
        .BYPASS   (BYPASS),
        .AW       (AW),
        .SW       (SW)
    ) u_lvt (
        .clk      (clk),
        .clr_en   (!ready),
        .clr_addr (clr_cnt),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_win   (wr_win),
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .rd_fwd   (rd_fwd)
    );

    always_ff @(posedge clk) begin
        for (int w = 0; w < WR_PORTS; w++) begin
            for (int r = 0; r < RD_PORTS; r++) begin
                if (!ready) begin
                    bank[w][r][clr_cnt] <= '0;
                end else if (wr_win[w]) begin
                    bank[w][r][wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rd_word[r] = '0;
            if (int'(rd_addr[r]) < DEPTH) begin
                if (rd_fwd[r]) begin
                    rd_word[r] = wr_data[rd_sel[r]];
                end else begin
                    rd_word[r] = bank[rd_sel[r]][r][rd_addr[r]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_conflict <= 1'b0;
            for (int r = 0; r < RD_PORTS; r++) begin
                rd_data[r]  <= '0;
                rd_valid[r] <= 1'b0;
            end
        end else begin
            wr_conflict <= conflict_d;
            for (int r = 0; r < RD_PORTS; r++) begin
                rd_valid[r] <= rd_en[r] && ready;
                if (rd_en[r] && ready) begin
                    rd_data[r] <= rd_word[r];
                end
            end
        end
    end

endmodule
